// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   - loader_state_e : frame-parser states
//   - loader_status_e: externally visible completion codes
//   - HdrBytes / WordBytes: frame geometry
// Optional build macro LOADER_CHECKSUM_EN enables the trailing checksum byte; the enum always
// carries StCsum so the encoding is identical in both builds.
package imem_loader_pkg;

    localparam int unsigned HdrBytes  = 2;  // 16-bit word count, MSB first
    localparam int unsigned WordBytes = 4;  // big-endian 32-bit words

    typedef enum logic [2:0] {
        StHdrHi,
        StHdrLo,
        StData,
        StCsum,
        StDone,
        StErr
    } loader_state_e;

    typedef enum logic [1:0] {
        StatusBusy  = 2'b00,
        StatusDone  = 2'b01,
        StatusError = 2'b10
    } loader_status_e;

    // States in which the loader is willing to take a stream byte.
    function automatic logic accepts_bytes(input loader_state_e s);
        return (s == StHdrHi) || (s == StHdrLo) || (s == StData) || (s == StCsum);
    endfunction

    function automatic loader_status_e status_of(input loader_state_e s);
        case (s)
            StDone:  return StatusDone;
            StErr:   return StatusError;
            default: return StatusBusy;
        endcase
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a byte stream into big-endian 32-bit words.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clear_i         synchronous clear (abandon any partial word)
//   byte_valid_i    a byte is being consumed this cycle
//   byte_i          the byte
//   byte_idx_o      position (0..3) the next consumed byte will occupy
//   word_valid_o    high for one cycle, the cycle after the 4th byte of a word was consumed
//   word_o          assembled word (valid while word_valid_o is high)
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [1:0]  byte_idx_o,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    localparam logic [1:0] LastIdx = 2'(WordBytes - 1);

    logic [1:0]  idx_q;
    logic [31:0] shreg_q;
    logic        word_valid_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q        <= '0;
            shreg_q      <= '0;
            word_valid_q <= 1'b0;
        end else if (clear_i) begin
            idx_q        <= '0;
            shreg_q      <= '0;
            word_valid_q <= 1'b0;
        end else begin
            word_valid_q <= byte_valid_i && (idx_q == LastIdx);
            if (byte_valid_i) begin
                // MSB arrives first, so shifting left leaves it in [31:24] after four bytes.
                shreg_q <= {shreg_q[23:0], byte_i};
                idx_q   <= idx_q + 2'd1;
            end
        end
    end

    assign byte_idx_o   = idx_q;
    assign word_valid_o = word_valid_q;
    assign word_o       = shreg_q;

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a framed byte stream over valid/ready, packs it into
// big-endian words written at consecutive word addresses, and holds the datapath in reset
// until the frame has loaded cleanly.
// Frame: CNT_HI, CNT_LO (word count N), 4*N payload bytes, [checksum byte].
// Build macro LOADER_CHECKSUM_EN: when defined, a trailing byte equal to the XOR of all payload
// bytes is required (mismatch -> error). When undefined, payload completion goes straight to done.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   restart_i            synchronous pulse: abandon frame, start a new one
//   in_valid_i/in_ready_o/in_byte_i   byte stream handshake
//   wr_en_o, wr_addr_o, wr_data_o     instruction-memory write port (one strobe per word)
//   cpu_reset_o          active-high datapath reset, released the cycle after done
//   done_o, error_o      frame accepted / frame rejected (levels)
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              restart_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [7:0]        in_byte_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [31:0]       wr_data_o,
    output logic              cpu_reset_o,
    output logic              done_o,
    output logic              error_o
);

    localparam int unsigned       Capacity = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] AddrMax  = '1;
    localparam logic [1:0]        LastIdx  = 2'(WordBytes - 1);

    // Where the parser goes once the last payload word (or an empty payload) is in.
`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_e StPayloadEnd = StCsum;
`else
    localparam loader_state_e StPayloadEnd = StDone;
`endif

    loader_state_e     state_q, state_d;
    logic              ready_q;
    logic              cpu_reset_q;
    logic              done_q;
    logic              error_q;
    logic [15:0]       count_q;   // N from the header
    logic [15:0]       words_q;   // payload words completed so far
    logic [ADDR_W-1:0] addr_q;

    logic              accept;
    logic              data_accept;
    logic              word_last_byte;
    logic [15:0]       count_rx;
    logic [1:0]        byte_idx;
    logic              pk_word_valid;
    logic [31:0]       pk_word;

    // restart wins over a concurrent byte by dropping ready combinationally.
    assign in_ready_o     = ready_q & ~restart_i;
    assign accept         = in_valid_i & in_ready_o;
    assign data_accept    = accept & (state_q == StData);
    assign word_last_byte = data_accept & (byte_idx == LastIdx);
    assign count_rx       = {count_q[15:8], in_byte_i};

    imem_loader_byte_packer u_packer (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (restart_i),
        .byte_valid_i (data_accept),
        .byte_i       (in_byte_i),
        .byte_idx_o   (byte_idx),
        .word_valid_o (pk_word_valid),
        .word_o       (pk_word)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            csum_q <= '0;
        end else if (restart_i) begin
            csum_q <= '0;
        end else if (data_accept) begin
            csum_q <= csum_q ^ in_byte_i;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        if (restart_i) begin
            state_d = StHdrHi;
        end else if (accept) begin
            unique case (state_q)
                StHdrHi: state_d = StHdrLo;
                StHdrLo: begin
                    if (32'(count_rx) > Capacity) begin
                        state_d = StErr;
                    end else if (count_rx == 16'd0) begin
                        state_d = StPayloadEnd;
                    end else begin
                        state_d = StData;
                    end
                end
                StData: begin
                    if (word_last_byte && ((words_q + 16'd1) == count_q)) begin
                        state_d = StPayloadEnd;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                StCsum: state_d = (in_byte_i == csum_q) ? StDone : StErr;
`endif
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StHdrHi;
            ready_q     <= 1'b0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            count_q     <= '0;
            words_q     <= '0;
            addr_q      <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= accepts_bytes(state_d);
            done_q  <= (status_of(state_d) == StatusDone);
            error_q <= (status_of(state_d) == StatusError);
            if (restart_i) begin
                cpu_reset_q <= 1'b1;
                count_q     <= '0;
                words_q     <= '0;
                addr_q      <= '0;
            end else begin
                // One-cycle lag: the last word's write strobe completes before release.
                cpu_reset_q <= (state_q != StDone);
                if (accept && (state_q == StHdrHi)) begin
                    count_q[15:8] <= in_byte_i;
                end
                if (accept && (state_q == StHdrLo)) begin
                    count_q[7:0] <= in_byte_i;
                end
                if (word_last_byte) begin
                    words_q <= words_q + 16'd1;
                end
                // Header check bounds N, so saturating at the top address never loses a write.
                if (pk_word_valid && (addr_q != AddrMax)) begin
                    addr_q <= addr_q + ADDR_W'(1);
                end
            end
        end
    end

    assign wr_en_o     = pk_word_valid;
    assign wr_addr_o   = addr_q;
    assign wr_data_o   = pk_word;
    assign cpu_reset_o = cpu_reset_q;
    assign done_o      = done_q;
    assign error_o     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus randomized frames and stalls,
// checked against a frame-level model (expected write list, checksum, final status).
module tb_imem_loader;

    localparam int unsigned AW  = 10;
    localparam int          CAP = 1 << AW;

    logic          clk;
    logic          rst_n;
    logic          restart;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_byte;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          cpu_reset;
    logic          done;
    logic          error;

    int checks = 0;
    int errors = 0;

    logic [63:0] got[$];   // observed writes as {addr, data}
    logic [31:0] fw[$];    // payload words of the frame under test

    imem_loader #(.ADDR_W(AW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .restart_i   (restart),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_byte_i   (in_byte),
        .wr_en_o     (wr_en),
        .wr_addr_o   (wr_addr),
        .wr_data_o   (wr_data),
        .cpu_reset_o (cpu_reset),
        .done_o      (done),
        .error_o     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && wr_en) got.push_back((64'(wr_addr) << 32) | 64'(wr_data));
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_wr_data"}, wr_data, 0);
        check({tag, "_cpu_reset"}, cpu_reset, 1);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
    endtask

    // mode 0: back-to-back, 1: idle cycle before every byte, 2: random idle cycles
    task automatic send_byte(input logic [7:0] b, input int mode, output bit ok);
        ok = 1'b0;
        if (mode == 1 || (mode == 2 && $urandom_range(0, 3) == 0)) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_byte  = b;
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_restart();
        @(negedge clk);
        in_valid = 1'b0;
        restart  = 1'b1;
        @(negedge clk);
        restart  = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int n, input int mode, input bit bad);
        logic [7:0] bytes[$];
        logic [7:0] x;
        logic [7:0] b;
        int acc;
        int exp_writes;
        int exp_addr;
        bit exp_done;
        bit ok;
        got.delete();
        acc = 0;
        x = '0;
        bytes.push_back(8'(n >> 8));
        bytes.push_back(8'(n));
        if (n > CAP) begin
            exp_writes = 0;
            exp_done   = 1'b0;
            exp_addr   = 0;
        end else begin
            while (fw.size() < n) fw.push_back($urandom);
            for (int i = 0; i < n; i++) begin
                for (int k = 3; k >= 0; k--) begin
                    b = 8'(fw[i] >> (8 * k));
                    bytes.push_back(b);
                    x ^= b;
                end
            end
            exp_writes = n;
            exp_addr   = (n < CAP) ? n : CAP - 1;
`ifdef LOADER_CHECKSUM_EN
            bytes.push_back(bad ? ~x : x);
            exp_done = !bad;
`else
            exp_done = 1'b1;
`endif
        end
        for (int i = 0; i < bytes.size(); i++) begin
            send_byte(bytes[i], mode, ok);
            if (!ok) break;
            acc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check({tag, "_accepted"}, acc, bytes.size());
        check({tag, "_nwrites"}, got.size(), exp_writes);
        for (int i = 0; i < exp_writes && i < got.size(); i++) begin
            check({tag, "_write"}, got[i], (64'(i) << 32) | 64'(fw[i]));
        end
        check({tag, "_done"}, done, exp_done);
        check({tag, "_error"}, error, !exp_done);
        check({tag, "_cpu_reset"}, cpu_reset, !exp_done);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_wr_addr"}, wr_addr, exp_addr);
        fw.delete();
    endtask

    initial begin
        bit ok;
        int n;
        rst_n    = 1'b0;
        restart  = 1'b0;
        in_valid = 1'b0;
        in_byte  = '0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;

        // Reference frame, back-to-back then with in_valid toggling.
        fw.push_back(32'h20080005);
        fw.push_back(32'h01095020);
        run_frame("n2", 2, 0, 1'b0);
        do_restart();
        fw.push_back(32'h20080005);
        fw.push_back(32'h01095020);
        run_frame("n2_toggle", 2, 1, 1'b0);

        do_restart();
        run_frame("n0", 0, 0, 1'b0);

        do_restart();
        fw.push_back(32'h20080005);
        fw.push_back(32'h01095020);
        run_frame("badcsum", 2, 2, 1'b1);

        do_restart();
        run_frame("oversize", 16'h0401, 0, 1'b0);

        // Restart on the 3rd payload byte; also clears the error left by the previous frame.
        do_restart();
        check("rst_from_err_error", error, 0);
        send_byte(8'h00, 0, ok);
        send_byte(8'h02, 0, ok);
        send_byte(8'h11, 0, ok);
        send_byte(8'h22, 0, ok);
        @(negedge clk);
        restart  = 1'b1;
        in_valid = 1'b1;
        in_byte  = 8'h33;
        #1;
        check("restart_in_ready", in_ready, 0);
        @(negedge clk);
        restart  = 1'b0;
        in_valid = 1'b0;
        check("restart_done", done, 0);
        check("restart_error", error, 0);
        check("restart_cpu_reset", cpu_reset, 1);
        check("restart_wr_addr", wr_addr, 0);
        run_frame("after_restart", 3, 2, 1'b0);

        // Reset between the 2nd and 3rd payload bytes.
        do_restart();
        send_byte(8'h00, 0, ok);
        send_byte(8'h01, 0, ok);
        send_byte(8'hA5, 0, ok);
        send_byte(8'h5A, 0, ok);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_reset_vals("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        run_frame("after_reset", 2, 2, 1'b0);

        for (int k = 0; k < 6; k++) begin
            do_restart();
            n = $urandom_range(1, 12);
            run_frame("rand", n, 2, ($urandom_range(0, 3) == 0));
        end

        // Exactly fills the memory: last address used, no wrap.
        do_restart();
        run_frame("full", CAP, 2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
